jt900h_rfile_wb: RTL and testbench



---
 rtl/jt900h_rfile_wb_pkg.sv | 59 +++++
 rtl/jt900h_rdec.sv | 47 ++++
 rtl/jt900h_rfile_wb.sv | 115 +++++++++++
 tb/tb_jt900h_rfile_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_rfile_wb_pkg.sv
// jt900h_rfile_wb_pkg
//   Shared definitions for the TLCS-900H register file / write-back slice:
//   one-hot width codes, register-code bank prefixes, global register
//   indices, the pending-write record and byte-lane helper functions.
package jt900h_rfile_wb_pkg;

   localparam logic [2:0] W_BYTE = 3'b001;
   localparam logic [2:0] W_WORD = 3'b010;
   localparam logic [2:0] W_LONG = 3'b100;

   localparam logic [3:0] CODE_PREV = 4'hD;
   localparam logic [3:0] CODE_CUR  = 4'hE;
   localparam logic [3:0] CODE_GLB  = 4'hF;

   typedef enum logic [1:0] {
      G_XIX = 2'd0,
      G_XIY = 2'd1,
      G_XIZ = 2'd2,
      G_XSP = 2'd3
   } glb_e;

   // 4 banks x 4 registers occupy 0..15, globals sit at 16..19
   localparam int unsigned NREGS   = 20;
   localparam logic [4:0]  IDX_XSP = {1'b1, 2'b00, G_XSP};

   typedef struct packed {
      logic [4:0]  idx;
      logic [3:0]  be;
      logic [31:0] data;   // already shifted into its byte lanes
   } wpend_t;

   // Byte enables for an access of width w starting at (aligned) lane
   function automatic logic [3:0] lane_be(input logic [2:0] w, input logic [1:0] lane);
      if (w[2])      return 4'b1111;
      else if (w[1]) return lane[1] ? 4'b1100 : 4'b0011;
      else           return 4'b0001 << lane;
   endfunction

   // Overlay the enabled bytes of data onto word
   function automatic logic [31:0] merge(input logic [31:0] word, input logic [3:0] be,
                                         input logic [31:0] data);
      logic [31:0] r;
      r = word;
      for (int unsigned b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   // Extract the width-aligned field at lane, zero-extended
   function automatic logic [31:0] field(input logic [31:0] word, input logic [2:0] w,
                                         input logic [1:0] lane);
      logic [31:0] s;
      s = word >> {lane, 3'b000};
      if (w[2])      return s;
      else if (w[1]) return {16'h0000, s[15:0]};
      else           return {24'h000000, s[7:0]};
   endfunction

endpackage

// File: rtl/jt900h_rdec.sv
// jt900h_rdec
//   Combinational register-code decoder.
//   code_i   : TLCS-900H register code
//   rfp_i    : current bank pointer
//   w_i      : one-hot access width (long > word > byte if several bits set)
//   valid_o  : code addresses a real register
//   idx_o    : physical index {global, bank, reg}
//   lane_o   : width-aligned starting byte lane
//   forced_o : alignment had to clear low code bits
module jt900h_rdec
   import jt900h_rfile_wb_pkg::*;
(
   input  logic [7:0] code_i,
   input  logic [1:0] rfp_i,
   input  logic [2:0] w_i,
   output logic       valid_o,
   output logic [4:0] idx_o,
   output logic [1:0] lane_o,
   output logic       forced_o
);

   always_comb begin
      valid_o = 1'b1;
      idx_o   = '0;
      case (code_i[7:4])
         4'h0, 4'h1, 4'h2, 4'h3: idx_o = {1'b0, code_i[5:4], code_i[3:2]};
         CODE_PREV:              idx_o = {1'b0, rfp_i - 2'd1, code_i[3:2]};
         CODE_CUR:               idx_o = {1'b0, rfp_i, code_i[3:2]};
         CODE_GLB:               idx_o = {1'b1, 2'b00, code_i[3:2]};
         default:                valid_o = 1'b0;
      endcase
   end

   always_comb begin
      if (w_i[2]) begin
         lane_o   = 2'b00;
         forced_o = |code_i[1:0];
      end else if (w_i[1]) begin
         lane_o   = {code_i[1], 1'b0};
         forced_o = code_i[0];
      end else begin
         lane_o   = code_i[1:0];
         forced_o = 1'b0;
      end
   end

endmodule

// File: rtl/jt900h_rfile_wb.sv
// jt900h_rfile_wb
//   Register file + write-back stage behind the ALU. Writes are captured
//   into a one-entry pending stage and committed on the following cen edge;
//   two combinational read ports forward from the pending entry per byte.
//   clk, rst (async, active-high), cen    : clocking
//   rfp                                   : current bank pointer
//   wr_addr, alu_we, wr_data              : ALU result write request
//   rd0_addr, rd0_w -> op0                : read port 0
//   rd1_addr, rd1_w -> op1                : read port 1
//   pend                                  : a write is pending
//   misalign                              : captured write needed alignment
module jt900h_rfile_wb
   import jt900h_rfile_wb_pkg::*;
#(
   parameter logic [31:0] SP_RST = 32'h0000_0100,
   parameter int          BANKS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [1:0]  rfp,
   input  logic [7:0]  wr_addr,
   input  logic [2:0]  alu_we,
   input  logic [31:0] wr_data,
   input  logic [7:0]  rd0_addr,
   input  logic [2:0]  rd0_w,
   output logic [31:0] op0,
   input  logic [7:0]  rd1_addr,
   input  logic [2:0]  rd1_w,
   output logic [31:0] op1,
   output logic        pend,
   output logic        misalign
);

   if (BANKS != 4) begin : g_banks_chk
      $error("jt900h_rfile_wb: BANKS must be 4");
   end

   logic [31:0] regs_q [NREGS];
   wpend_t      wp_q, wp_d;
   logic        pend_q, pend_d;
   logic        misalign_q;

   logic       w_valid, w_forced, r0_valid, r0_forced, r1_valid, r1_forced;
   logic [4:0] w_idx, r0_idx, r1_idx;
   logic [1:0] w_lane, r0_lane, r1_lane;
   logic       capture;

   jt900h_rdec u_wdec (
      .code_i(wr_addr), .rfp_i(rfp), .w_i(alu_we),
      .valid_o(w_valid), .idx_o(w_idx), .lane_o(w_lane), .forced_o(w_forced)
   );

   jt900h_rdec u_rd0dec (
      .code_i(rd0_addr), .rfp_i(rfp), .w_i(rd0_w),
      .valid_o(r0_valid), .idx_o(r0_idx), .lane_o(r0_lane), .forced_o(r0_forced)
   );

   jt900h_rdec u_rd1dec (
      .code_i(rd1_addr), .rfp_i(rfp), .w_i(rd1_w),
      .valid_o(r1_valid), .idx_o(r1_idx), .lane_o(r1_lane), .forced_o(r1_forced)
   );

   assign capture = cen & (|alu_we) & w_valid;

   always_comb begin
      wp_d   = wp_q;
      pend_d = pend_q;
      if (cen) begin
         pend_d = capture;
         if (capture) begin
            wp_d.idx  = w_idx;
            wp_d.be   = lane_be(alu_we, w_lane);
            wp_d.data = wr_data << {w_lane, 3'b000};
         end
      end
   end

   // Commit of the old entry and capture of a new one share the same edge;
   // the new entry stays pending and overlays the committed value on reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i[4:0]] <= '0;
         regs_q[IDX_XSP] <= SP_RST;
         wp_q       <= '0;
         pend_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= capture & w_forced;
         if (cen) begin
            if (pend_q) regs_q[wp_q.idx] <= merge(regs_q[wp_q.idx], wp_q.be, wp_q.data);
            wp_q   <= wp_d;
            pend_q <= pend_d;
         end
      end
   end

   always_comb begin
      logic [31:0] w0, w1;
      w0 = regs_q[r0_idx];
      w1 = regs_q[r1_idx];
      if (pend_q && wp_q.idx == r0_idx) w0 = merge(w0, wp_q.be, wp_q.data);
      if (pend_q && wp_q.idx == r1_idx) w1 = merge(w1, wp_q.be, wp_q.data);
      op0 = r0_valid ? field(w0, rd0_w, r0_lane) : '0;
      op1 = r1_valid ? field(w1, rd1_w, r1_lane) : '0;
   end

   assign pend     = pend_q;
   assign misalign = misalign_q;

   // Read-side alignment forcing has no observable effect
   logic unused_ok;
   assign unused_ok = r0_forced ^ r1_forced;

endmodule

// File: tb/tb_jt900h_rfile_wb.sv
module tb_jt900h_rfile_wb;

   localparam logic [2:0] LB = 3'b001, LW = 3'b010, LL = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic [1:0]  rfp = 2'd0;
   logic [7:0]  wr_addr = 8'h00;
   logic [2:0]  alu_we = 3'b000;
   logic [31:0] wr_data = 32'h0;
   logic [7:0]  rd0_addr = 8'h00;
   logic [2:0]  rd0_w = LL;
   logic [7:0]  rd1_addr = 8'h00;
   logic [2:0]  rd1_w = LL;
   logic [31:0] op0, op1;
   logic        pend, misalign;

   jt900h_rfile_wb #(.SP_RST(32'h0000_0100), .BANKS(4)) dut (
      .clk(clk), .rst(rst), .cen(cen), .rfp(rfp),
      .wr_addr(wr_addr), .alu_we(alu_we), .wr_data(wr_data),
      .rd0_addr(rd0_addr), .rd0_w(rd0_w), .op0(op0),
      .rd1_addr(rd1_addr), .rd1_w(rd1_w), .op1(op1),
      .pend(pend), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [20];
   bit          m_pend;
   int          m_idx;
   logic [3:0]  m_be;
   logic [31:0] m_data;
   bit          m_mis;

   function automatic bit m_dec(input logic [7:0] code, input logic [1:0] r, output int idx);
      int hi, rg;
      hi = int'(code[7:4]);
      rg = int'(code[3:2]);
      idx = 0;
      if (hi < 4)         idx = hi * 4 + rg;
      else if (hi == 13)  idx = ((int'(r) + 3) % 4) * 4 + rg;
      else if (hi == 14)  idx = int'(r) * 4 + rg;
      else if (hi == 15)  idx = 16 + rg;
      else return 1'b0;
      return 1'b1;
   endfunction

   function automatic int m_lane(input logic [7:0] code, input logic [2:0] w);
      if (w == LL) return 0;
      if (w == LW) return code[1] ? 2 : 0;
      return int'(code[1:0]);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] code, input logic [2:0] w);
      int idx;
      logic [31:0] v;
      if (!m_dec(code, rfp, idx)) return 32'h0;
      v = m_regs[idx];
      if (m_pend && m_idx == idx)
         for (int b = 0; b < 4; b++)
            if (m_be[b]) v[8*b +: 8] = m_data[8*b +: 8];
      v = v >> (8 * m_lane(code, w));
      if (w == LL) return v;
      if (w == LW) return v & 32'h0000_FFFF;
      return v & 32'h0000_00FF;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 20; i++) m_regs[i] = 32'h0;
      m_regs[19] = 32'h0000_0100;
      m_pend = 1'b0;
      m_idx  = 0;
      m_be   = 4'h0;
      m_data = 32'h0;
      m_mis  = 1'b0;
   endtask

   task automatic m_clock();
      int idx, lane, nb;
      bit ok;
      if (!cen) begin
         m_mis = 1'b0;
         return;
      end
      if (m_pend)
         for (int b = 0; b < 4; b++)
            if (m_be[b]) m_regs[m_idx][8*b +: 8] = m_data[8*b +: 8];
      ok = m_dec(wr_addr, rfp, idx);
      if (alu_we != 3'b000 && ok) begin
         lane = m_lane(wr_addr, alu_we);
         nb = (alu_we == LL) ? 4 : (alu_we == LW) ? 2 : 1;
         m_mis  = (alu_we == LL) ? (wr_addr[1:0] != 2'b00) :
                  (alu_we == LW) ? wr_addr[0] : 1'b0;
         m_pend = 1'b1;
         m_idx  = idx;
         m_be   = 4'h0;
         m_data = 32'h0;
         for (int b = 0; b < nb; b++) begin
            m_be[lane + b] = 1'b1;
            m_data[8*(lane + b) +: 8] = wr_data[8*b +: 8];
         end
      end else begin
         m_pend = 1'b0;
         m_mis  = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] s_op0, s_op1;
   logic        s_pend, s_mis;

   task automatic cyc(input bit c, input logic [1:0] r, input logic [7:0] wa,
                      input logic [2:0] we, input logic [31:0] wd,
                      input logic [7:0] a0, input logic [2:0] w0,
                      input logic [7:0] a1, input logic [2:0] w1);
      @(negedge clk);
      cen = c; rfp = r; wr_addr = wa; alu_we = we; wr_data = wd;
      rd0_addr = a0; rd0_w = w0; rd1_addr = a1; rd1_w = w1;
      #1;
      s_op0 = op0; s_op1 = op1; s_pend = pend; s_mis = misalign;
      chk("op0", op0, m_read(a0, w0));
      chk("op1", op1, m_read(a1, w1));
      chk("pend", {31'h0, pend}, {31'h0, m_pend});
      chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
      @(posedge clk);
      m_clock();
   endtask

   task automatic do_reset(input logic [7:0] a0);
      @(negedge clk);
      chk("pre_rst_pend", {31'h0, pend}, {31'h0, m_pend});
      rst = 1'b1; alu_we = 3'b000; rd0_addr = a0; rd0_w = LL;
      m_reset();
      #1;
      s_op0 = op0;
      chk("rst_pend", {31'h0, pend}, 32'h0);
      chk("rst_misalign", {31'h0, misalign}, 32'h0);
      chk("rst_op0", op0, m_read(a0, LL));
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [7:0] rand_code();
      logic [3:0] hi;
      case ($urandom_range(0, 7))
         0: hi = 4'h0;
         1: hi = 4'h1;
         2: hi = 4'h2;
         3: hi = 4'h3;
         4: hi = 4'hD;
         5: hi = 4'hE;
         6: hi = 4'hF;
         default: hi = 4'($urandom);
      endcase
      return {hi, 4'($urandom)};
   endfunction

   function automatic logic [2:0] rand_w(input bit allow_none);
      int k;
      k = allow_none ? $urandom_range(0, 3) : $urandom_range(1, 3);
      return (k == 0) ? 3'b000 : (k == 1) ? LB : (k == 2) ? LW : LL;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      do_reset(8'hFC);

      // reset contents
      cyc(1, 2'd0, 8'h00, 3'b000, 32'h0, 8'hFC, LL, 8'h00, LL);
      chk("rst_xsp", s_op0, 32'h0000_0100);
      chk("rst_xwa", s_op1, 32'h0);

      // long write through current bank, forwarded then committed
      cyc(1, 2'd2, 8'hE0, LL, 32'h1122_3344, 8'hFC, LL, 8'h00, LL);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'h20, LL, 8'h20, LW);
      chk("fwd_long", s_op0, 32'h1122_3344);
      chk("fwd_pend", {31'h0, s_pend}, 32'h1);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'h20, LL, 8'h22, LW);
      chk("arr_long", s_op0, 32'h1122_3344);
      chk("arr_pend", {31'h0, s_pend}, 32'h0);

      // byte overlay forwarding
      cyc(1, 2'd2, 8'hE1, LB, 32'h0000_00AA, 8'h20, LL, 8'h00, LL);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'h20, LL, 8'h21, LB);
      chk("fwd_byte", s_op0, 32'h1122_AA44);
      chk("fwd_byte_b", s_op1, 32'h0000_00AA);

      // cen low: write ignored, nothing changes
      cyc(0, 2'd2, 8'hE0, LL, 32'h5555_5555, 8'h20, LL, 8'h00, LL);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'h20, LL, 8'h00, LL);
      chk("cen0_hold", s_op0, 32'h1122_AA44);
      chk("cen0_pend", {31'h0, s_pend}, 32'h0);

      // misaligned word to XIX
      cyc(1, 2'd2, 8'hF3, LW, 32'h0000_BEEF, 8'h00, LL, 8'h00, LL);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'hF0, LL, 8'hF2, LW);
      chk("mis_pulse", {31'h0, s_mis}, 32'h1);
      chk("mis_xix", s_op0, 32'hBEEF_0000);
      chk("mis_word", s_op1, 32'h0000_BEEF);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'hF0, LL, 8'h00, LL);
      chk("mis_clear", {31'h0, s_mis}, 32'h0);

      // back-to-back writes, rfp change while pending
      cyc(1, 2'd0, 8'h10, LL, 32'h1, 8'h10, LL, 8'h00, LL);
      cyc(1, 2'd0, 8'h10, LL, 32'h2, 8'h10, LL, 8'h00, LL);
      chk("b2b_first", s_op0, 32'h1);
      cyc(1, 2'd1, 8'h00, 3'b000, 32'h0, 8'h10, LL, 8'h00, LL);
      chk("b2b_second", s_op0, 32'h2);
      chk("b2b_pend", {31'h0, s_pend}, 32'h1);
      cyc(1, 2'd2, 8'h00, 3'b000, 32'h0, 8'hD0, LL, 8'h10, LL);
      chk("prev_bank", s_op0, 32'h2);
      chk("b2b_commit", s_pend, 1'b0);

      // reset while a write is pending
      cyc(1, 2'd0, 8'h30, LL, 32'hDEAD_BEEF, 8'h00, LL, 8'h00, LL);
      do_reset(8'h30);
      chk("rst_lost", s_op0, 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset(rand_code());
         else
            cyc($urandom_range(0, 3) != 0, 2'($urandom), rand_code(), rand_w(1'b1), $urandom,
                rand_code(), rand_w(1'b0), rand_code(), rand_w(1'b0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
